// File: rtl/adder_pkg.sv
// Shared types and default widths for the chunked serial adder.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned DefNumBits   = 32;
    localparam int unsigned DefChunkBits = 8;

endpackage

// File: rtl/chunk_adder.sv
// Combinational ripple adder for one chunk; also exposes the carry into its MSB
// so the caller can derive signed overflow on the final chunk.
module chunk_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_msb_o,
    output logic             carry_o
);

    always_comb begin
        logic c;
        c           = carry_i;
        sum_o       = '0;
        carry_msb_o = carry_i;
        for (int i = 0; i < int'(WIDTH); i++) begin
            // Last value written is the carry entering bit WIDTH-1.
            carry_msb_o = c;
            sum_o[i]    = a_i[i] ^ b_i[i] ^ c;
            c           = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
        end
        carry_o = c;
    end

endmodule

// File: rtl/serial_adder_nbit.sv
// Multi-cycle adder: NUM_BITS operands summed CHUNK_BITS per cycle, LSB chunk first.
// Define ADDER_ASSERT_EN to enable input X-checks and the width divisibility check.
module serial_adder_nbit
    import adder_pkg::*;
#(
    parameter int unsigned NUM_BITS   = DefNumBits,
    parameter int unsigned CHUNK_BITS = DefChunkBits
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic                carry_in,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] sum,
    output logic                carry_out,
    output logic                overflow
);

    localparam int unsigned NumChunks = NUM_BITS / CHUNK_BITS;
    localparam int unsigned IdxW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumChunks - 1);

    state_e              state_q, state_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [NUM_BITS-1:0] a_q, a_d;
    logic [NUM_BITS-1:0] b_q, b_d;
    logic                carry_q, carry_d;
    logic [NUM_BITS-1:0] sum_q, sum_d;
    logic                carry_out_q, carry_out_d;
    logic                overflow_q, overflow_d;

    logic [CHUNK_BITS-1:0] chunk_a, chunk_b, chunk_sum;
    logic                  chunk_carry_msb, chunk_carry;

    assign chunk_a = a_q[idx_q*CHUNK_BITS +: CHUNK_BITS];
    assign chunk_b = b_q[idx_q*CHUNK_BITS +: CHUNK_BITS];

    chunk_adder #(
        .WIDTH (CHUNK_BITS)
    ) u_chunk_adder (
        .a_i         (chunk_a),
        .b_i         (chunk_b),
        .carry_i     (carry_q),
        .sum_o       (chunk_sum),
        .carry_msb_o (chunk_carry_msb),
        .carry_o     (chunk_carry)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        sum_d       = sum_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = carry_in;
                    idx_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                sum_d[idx_q*CHUNK_BITS +: CHUNK_BITS] = chunk_sum;
                carry_d = chunk_carry;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LastIdx) begin
                    carry_out_d = chunk_carry;
                    overflow_d  = chunk_carry_msb ^ chunk_carry;
                    idx_d       = '0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            sum_q       <= sum_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        busy      = (state_q == ADD);
        done      = (state_q == DONE);
        sum       = sum_q;
        carry_out = carry_out_q;
        overflow  = overflow_q;
    end

`ifdef ADDER_ASSERT_EN
    if (NUM_BITS % CHUNK_BITS != 0) begin : g_width_check
        $fatal(1, "serial_adder_nbit: NUM_BITS must be a multiple of CHUNK_BITS");
    end

    always_ff @(posedge clk) begin
        if (!rst && state_q == IDLE && start) begin
            if ($isunknown(a)) $error("serial_adder_nbit: operand a has X/Z bits at start");
            if ($isunknown(b)) $error("serial_adder_nbit: operand b has X/Z bits at start");
            if ($isunknown(carry_in)) $error("serial_adder_nbit: carry_in is X/Z at start");
        end
    end
`endif

endmodule
